// File: rtl/io_pixel_streamer.sv
// Memory read-out streamer: walks a word range, splits each word into PIXEL-bit
// pixels (MSB first) and presents them one at a time on a valid/ready port.
module io_pixel_streamer #(
    parameter int WIDTH     = 24,
    parameter int PIXEL     = 8,
    parameter int ADDR_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] word_count,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rd,
    output logic [PIXEL-1:0] px_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int PPW  = WIDTH / PIXEL;
    localparam int IDXW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PPW - 1);

    if (WIDTH % PIXEL != 0) begin : g_bad_width
        $error("io_pixel_streamer: WIDTH must be a multiple of PIXEL");
    end

    // Pixel port: a pixel transfers on a cycle where px_valid && px_ready.
    // Once px_valid is raised it stays high with px_data frozen until that transfer.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAPT = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] word_q;
    logic [IDXW-1:0]  px_idx;
    logic             last_px;

    assign last_px   = (px_idx == LAST_IDX);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        px_valid = 1'b0;
        px_data  = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (word_count != '0) ? S_REQ : S_FIN;
                end
            end
            S_REQ:  state_nx = S_CAPT;
            S_CAPT: state_nx = S_EMIT;
            S_EMIT: begin
                px_valid = 1'b1;
                px_data  = word_q[(PPW - 1 - int'(px_idx)) * PIXEL +: PIXEL];
                if (px_ready && last_px) begin
                    state_nx = (remaining > WIDTH'(1)) ? S_REQ : S_FIN;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            word_q    <= '0;
            px_idx    <= '0;
            mem_addr  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start && word_count != '0) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                    end
                end
                S_REQ: mem_addr <= addr;
                S_CAPT: begin
                    word_q <= mem_rd;
                    px_idx <= '0;
                end
                S_EMIT: begin
                    if (px_ready) begin
                        if (last_px) begin
                            px_idx    <= '0;
                            remaining <= remaining - WIDTH'(1);
                            // Address only advances when another word follows; wraps naturally.
                            if (remaining > WIDTH'(1)) begin
                                addr <= addr + WIDTH'(ADDR_STEP);
                            end
                        end else begin
                            px_idx <= px_idx + IDXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
